led_trail_dimmer: RTL and testbench

Downstream stage of the light chaser. Takes the rotating one-hot LED pattern and drives each physical LED with PWM. Every lit position leaves a fading "comet tail" behind the moving light. Each channel holds a brightness level that is reloaded to full while its input bit is high, then decays in fixed steps at a programmable rate.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_pwm_channel.sv | 50 +++++
 rtl/led_trail_dimmer.sv | 76 +++++++
 tb/tb_led_trail_dimmer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED trail dimmer: default level width,
// the working width of the saturating subtractor and the subtractor itself.
package led_pkg;

    // Default brightness resolution and the matching full-on level.
    localparam int PWM_BITS_DEF = 4;
    localparam int MAX_DEF      = (1 << PWM_BITS_DEF) - 1;

    // Working width of sat_sub; callers zero-extend into it and take the low bits back.
    localparam int SAT_W = 16;

    // Brightness level at the default resolution.
    typedef logic [PWM_BITS_DEF-1:0] level_t;

    // Full-on level for a given resolution, expressed at the working width.
    function automatic logic [SAT_W-1:0] max_level(input int bits);
        return SAT_W'((1 << bits) - 1);
    endfunction

    // Unsigned subtraction that clamps at zero instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level register with load/decay and a registered
// PWM comparator against the shared period counter.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 4,
    parameter int DECAY_STEP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

    logic [PWM_BITS-1:0] level_reg;
    logic [PWM_BITS-1:0] level_next;
    logic [SAT_W-1:0]    dec_full;
    logic                pwm_out_reg;

    assign dec_full = sat_sub(SAT_W'(level_reg), SAT_W'(DECAY_STEP));

    // Load wins over decay; decay never goes below zero.
    always_comb begin
        level_next = level_reg;
        if (load) begin
            level_next = MAX;
        end else if (decay_tick) begin
            // dec_full never exceeds level_reg; the clamp only keeps the narrowing exact.
            level_next = (dec_full > SAT_W'(MAX)) ? MAX : dec_full[PWM_BITS-1:0];
        end
    end

    // Level and PWM drive registers; the comparator uses the current level and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg   <= '0;
            pwm_out_reg <= 1'b0;
        end else begin
            level_reg   <= level_next;
            pwm_out_reg <= (level_reg > pwm_cnt);
        end
    end

    assign pwm_out = pwm_out_reg;

endmodule

// File: rtl/led_trail_dimmer.sv
// Comet-tail dimmer: each lit input bit reloads its channel to full brightness,
// which then fades in fixed steps while the PWM period counter runs freely.
module led_trail_dimmer
    import led_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PWM_BITS    = 4,
    parameter int DECAY_TICKS = 64,
    parameter int DECAY_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] pwm_out,
    output logic             period_start
);

    // Decay counter needs at least one bit even when DECAY_TICKS is 1.
    localparam int                  DCW        = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'(max_level(PWM_BITS) - 1);
    localparam logic [DCW-1:0]      DECAY_LAST = DCW'(DECAY_TICKS - 1);

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [DCW-1:0]      decay_cnt_reg;
    logic [DCW-1:0]      decay_cnt_next;
    logic                decay_tick;
    logic                period_start_reg;

    // Period counter wraps after MAX-1 so a full period is MAX clocks.
    always_comb begin
        pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + PWM_BITS'(1);
    end

    // Decay prescaler only advances while enabled and keeps its phase when frozen.
    always_comb begin
        decay_tick     = enable && (decay_cnt_reg == DECAY_LAST);
        decay_cnt_next = decay_cnt_reg;
        if (enable) begin
            decay_cnt_next = (decay_cnt_reg == DECAY_LAST) ? '0 : decay_cnt_reg + DCW'(1);
        end
    end

    // Shared counters and the period-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg      <= '0;
            decay_cnt_reg    <= '0;
            period_start_reg <= 1'b0;
        end else begin
            pwm_cnt_reg      <= pwm_cnt_next;
            decay_cnt_reg    <= decay_cnt_next;
            period_start_reg <= (pwm_cnt_reg == '0);
        end
    end

    assign period_start = period_start_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            led_pwm_channel #(
                .PWM_BITS   (PWM_BITS),
                .DECAY_STEP (DECAY_STEP)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (led_in[gi]),
                .decay_tick (decay_tick),
                .pwm_cnt    (pwm_cnt_reg),
                .pwm_out    (pwm_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_trail_dimmer.sv
// Self-checking bench for led_trail_dimmer against a behavioural brightness model.
module tb_led_trail_dimmer;

    localparam int W    = 8;
    localparam int PB   = 4;
    localparam int MAXV = 15;
    localparam int DT   = 4;
    localparam int DS   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] led_in;
    logic [W-1:0] pwm_out;
    logic         period_start;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state: brightness per channel, PWM phase, decay phase.
    int           m_level [W];
    int           m_phase;
    int           m_dcnt;
    logic [W-1:0] exp_pwm;
    logic         exp_ps;

    led_trail_dimmer #(
        .WIDTH       (W),
        .PWM_BITS    (PB),
        .DECAY_TICKS (DT),
        .DECAY_STEP  (DS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .led_in       (led_in),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic int fade(input int l);
        return (l > DS) ? l - DS : 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Model: outputs are a registered view of the previous level/phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) m_level[i] <= 0;
            m_phase <= 0;
            m_dcnt  <= 0;
            exp_pwm <= '0;
            exp_ps  <= 1'b0;
        end else begin
            for (int i = 0; i < W; i++) begin
                exp_pwm[i] <= (m_level[i] > m_phase);
                if (led_in[i])                          m_level[i] <= MAXV;
                else if (enable && (m_dcnt == DT - 1))  m_level[i] <= fade(m_level[i]);
            end
            exp_ps  <= (m_phase == 0);
            m_phase <= (m_phase + 1) % MAXV;
            if (enable) m_dcnt <= (m_dcnt + 1) % DT;
        end
    end

    // Cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
            check("period_start", 32'(period_start), 32'(exp_ps));
        end
    end

    task automatic wait_level(input int v, input int budget, input string nm);
        int n = 0;
        while (m_level[0] != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(m_level[0]), 32'(v));
    endtask

    task automatic count_high0(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (pwm_out[0]) hits++;
        end
    endtask

    initial begin
        int hits, saved, steps, cur;
        int seq [5] = '{15, 11, 7, 3, 0};
        int duty [3] = '{11, 7, 3};

        // 1. Reset
        rst_n = 1'b1; enable = 1'b0; led_in = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_pwm_out", 32'(pwm_out), 32'h0);
        check("reset_period_start", 32'(period_start), 32'h0);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hits = 0; cur = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (period_start) hits++;
            if (i < 100 && pwm_out != '0) cur++;
        end
        check("period_start_count", 32'(hits), 32'd10);
        check("idle_pwm_nonzero", 32'(cur), 32'd0);

        // 2. Steady load
        enable = 1'b1; led_in = 8'h01;
        @(negedge clk);
        check("latency_first", 32'(pwm_out), 32'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("steady_load", 32'(pwm_out), 32'h01);
        end
        led_in = '0;

        // 3. Fade
        wait_level(0, 40, "fade_clear");
        repeat (5) @(negedge clk);
        led_in = 8'h01;
        @(negedge clk);
        led_in = '0;
        for (int k = 0; k < 5; k++) wait_level(seq[k], 6, "fade_step");
        repeat (2) @(negedge clk);
        count_high0(30, hits);
        check("faded_off", 32'(hits), 32'd0);

        // 4. Freeze
        led_in = 8'h01;
        @(negedge clk);
        led_in = '0; enable = 1'b0; saved = m_dcnt;
        repeat (2) @(negedge clk);
        count_high0(50, hits);
        check("freeze_on", 32'(hits), 32'd50);
        check("freeze_level", 32'(m_level[0]), 32'd15);
        check("freeze_dcnt", 32'(m_dcnt), 32'(saved));
        enable = 1'b1; steps = 0;
        while (m_level[0] == MAXV && steps < 10) begin
            @(negedge clk);
            steps++;
        end
        check("resume_steps", 32'(steps), 32'(DT - saved));

        // Duty per frozen level
        led_in = 8'h01;
        @(negedge clk);
        led_in = '0;
        for (int k = 0; k < 3; k++) begin
            enable = 1'b1;
            wait_level(duty[k], 8, "duty_reach");
            enable = 1'b0;
            repeat (2) @(negedge clk);
            count_high0(MAXV, hits);
            check("duty_count", 32'(hits), 32'(duty[k]));
        end

        // 5. Collision at level 3
        enable = 1'b1;
        steps = 0;
        while (m_dcnt != DT - 1 && steps < 8) begin
            @(negedge clk);
            steps++;
        end
        check("collide_pre_level", 32'(m_level[0]), 32'd3);
        led_in = 8'h01;
        @(negedge clk);
        led_in = '0;
        check("collide_level", 32'(m_level[0]), 32'd15);
        @(negedge clk);
        check("collide_pwm", 32'(pwm_out[0]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0:       led_in = 8'(1 << $urandom_range(0, W - 1));
                1:       led_in = 8'($urandom);
                2:       led_in = (i % 97 == 0) ? 8'hFF : '0;
                default: led_in = '0;
            endcase
            enable = ($urandom_range(0, 3) != 0);
        end
        led_in = '0; enable = 1'b1;

        // 6. Chase integration
        steps = 0;
        @(negedge clk);
        while (m_dcnt != 0 && steps < 8) begin
            @(negedge clk);
            steps++;
        end
        for (int r = 0; r < 12; r++) begin
            cur = r % W;
            led_in = 8'(1 << cur);
            repeat (DT) @(negedge clk);
            if (r >= 4) begin
                check("chase_lit", 32'(m_level[cur]), 32'd15);
                check("chase_t1", 32'(m_level[(cur + W - 1) % W]), 32'd11);
                check("chase_t2", 32'(m_level[(cur + W - 2) % W]), 32'd7);
                check("chase_t3", 32'(m_level[(cur + W - 3) % W]), 32'd3);
            end
        end
        check("chase_pwm_lit", 32'(pwm_out[cur]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_pwm", 32'(pwm_out), 32'h0);
        check("midrun_reset_ps", 32'(period_start), 32'h0);
        led_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
